random_lfsr_ext: RTL

//   Parametrised XNOR-feedback shift-register pseudo-random generator, polynomial 1+x^TAP+x^WIDTH.

---
 rtl/random_lfsr_ext.sv | 92 +++++++++
 1 files changed

// File: rtl/random_lfsr_ext.sv
// random_lfsr_ext
//   XNOR-feedback shift-register pseudo-random generator for the polynomial
//   1 + x^TAP + x^WIDTH. The all-ones-prefix correction term is folded into
//   the feedback, so a primitive polynomial walks all 2^WIDTH states,
//   including all-zeros and all-ones.
//
// Parameters
//   WIDTH  state/output width (>= 3)
//   TAP    second polynomial exponent, 1 <= TAP < WIDTH (tap bit s[TAP-1])
//   STEPS  single steps applied per enabled clock (1..WIDTH), unrolled
//   SEED   state value loaded by reset
//
// Ports
//   clk     rising-edge clock
//   rst     asynchronous reset, active high
//   en      advance the state by STEPS steps this cycle
//   load    load seed into the state this cycle (overrides en)
//   seed    value taken on load
//   random  current state (registered)
//   valid   high once random holds loaded or stepped data
//   wrap    one-cycle pulse when random returns to the captured start value
//
// Flow control: there is no valid/ready handshake. valid only says that
// random holds real data. The consumer controls the rate through en, and
// random changes only on a clock edge where en or load is high.
module random_lfsr_ext #(
  parameter int               WIDTH = 71,
  parameter int               TAP   = 65,
  parameter int               STEPS = 1,
  parameter logic [WIDTH-1:0] SEED  = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] random,
  output logic             valid,
  output logic             wrap
);

  logic [WIDTH-1:0] r_state;
  logic [WIDTH-1:0] r_start;
  logic             r_valid;
  logic             r_wrap;

  logic [WIDTH-1:0] w_next;

  // A single shift. The AND of the low bits flips the feedback in the two
  // states whose low WIDTH-1 bits are all ones. This splices the all-ones
  // state into the cycle, so no state locks up.
  function automatic logic [WIDTH-1:0] step_once(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ~(s[WIDTH-1] ^ s[TAP-1]) ^ (&s[WIDTH-2:0]);
    return {s[WIDTH-2:0], fb};
  endfunction

  // STEPS single steps chained combinationally, so there is no extra latency.
  always_comb begin
    w_next = r_state;
    for (int i = 0; i < STEPS; i++) begin
      w_next = step_once(w_next);
    end
  end

  // Priority is load > en > hold. wrap is recomputed on every edge, so it
  // can never stay high through a hold cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
      r_start <= SEED;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else if (load) begin
      r_state <= seed;
      r_start <= seed;
      r_valid <= 1'b1;
      r_wrap  <= 1'b0;
    end else if (en) begin
      r_state <= w_next;
      r_valid <= 1'b1;
      r_wrap  <= (w_next == r_start);
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign random = r_state;
  assign valid  = r_valid;
  assign wrap   = r_wrap;

endmodule
